// File: rtl/data_mem_sub_pkg.sv
// Shared encodings for the byte-addressable data memory.
// Access sizes and sweep/run FSM states.
package data_mem_sub_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/data_mem_sub_mem_lane_align.sv
// Lane merge for stores, extract/extend for loads,
// and the alignment legality check.
module mem_lane_align
  import data_mem_sub_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        sign_ext_i,
  output logic [31:0] new_word_o,
  output logic [31:0] rdata_o,
  output logic        legal_o
);

  logic [7:0]  rd_b;
  logic [15:0] rd_h;

  assign rd_b = old_word_i[{lane_i, 3'b000} +: 8];
  assign rd_h = old_word_i[{lane_i[1], 4'b0000} +: 16];

  // Legality, merged store word and extended load value.
  always_comb begin
    legal_o    = 1'b0;
    new_word_o = old_word_i;
    rdata_o    = old_word_i;
    unique case (1'b1)
      (size_i == SZ_BYTE): begin
        legal_o = 1'b1;
        new_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
        rdata_o = sign_ext_i ? {{24{rd_b[7]}}, rd_b}
                             : {24'h0, rd_b};
      end
      (size_i == SZ_HALF): begin
        legal_o = ~lane_i[0];
        new_word_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        rdata_o = sign_ext_i ? {{16{rd_h[15]}}, rd_h}
                             : {16'h0, rd_h};
      end
      (size_i == SZ_WORD): begin
        legal_o    = (lane_i == 2'b00);
        new_word_o = wdata_i;
        rdata_o    = old_word_i;
      end
      default: begin
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_sub.sv
// Byte-addressed data memory with hardware clear sweep,
// sized accesses and misalignment suppression.
module data_mem_sub
  import data_mem_sub_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wena,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              rvalid,
  output logic              ready,
  output logic              misalign
);

  localparam int IW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  state_e        state_q;
  logic [IW-1:0] cnt_q;
  logic [31:0]   data_out_q;
  logic          rvalid_q;
  logic          ready_q;
  logic          misalign_q;

  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [31:0]   merged;
  logic [31:0]   ext;
  logic          legal;
  logic          acc;
  logic          ld_ok;

  logic          we_d;
  logic [IW-1:0] widx_d;
  logic [31:0]   wword_d;

  assign idx     = addr[IW+1:2];
  assign lane    = addr[1:0];
  assign rd_word = mem_q[idx];
  assign acc     = ready_q & ena;
  assign ld_ok   = acc & ~wena & legal;

  generate
    if (ADDR_W > IW + 2) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^addr[ADDR_W-1:IW+2];
    end
  endgenerate

  mem_lane_align u_align (
    .old_word_i (rd_word),
    .wdata_i    (data_in),
    .size_i     (size),
    .lane_i     (lane),
    .sign_ext_i (sign_ext),
    .new_word_o (merged),
    .rdata_o    (ext),
    .legal_o    (legal)
  );

  // Single write port: sweep zeros, else legal stores.
  always_comb begin
    we_d    = 1'b0;
    widx_d  = idx;
    wword_d = merged;
    if (state_q == ST_CLEAR) begin
      we_d    = 1'b1;
      widx_d  = cnt_q;
      wword_d = 32'h0;
    end else if (acc && wena && legal) begin
      we_d = 1'b1;
    end
  end

  // Array update; contents are only cleared by the sweep.
  always_ff @(posedge clk) begin
    if (rst_n && we_d) begin
      mem_q[widx_d] <= wword_d;
    end
  end

  // Sweep/run FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      data_out_q <= 32'h0;
      rvalid_q   <= 1'b0;
      ready_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          rvalid_q   <= 1'b0;
          misalign_q <= 1'b0;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == IW'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          rvalid_q   <= ld_ok;
          misalign_q <= acc & ~legal;
          if (ld_ok) begin
            data_out_q <= ext;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
        end
      endcase
    end
  end

  assign data_out = data_out_q;
  assign rvalid   = rvalid_q;
  assign ready    = ready_q;
  assign misalign = misalign_q;

endmodule
